riscv_writeback_stage: RTL
==========================

# riscv_writeback_stage

Final pipeline stage of the RV32I core, sitting directly upstream of the register file write port. Accepts one completed instruction per cycle from the memory stage, selects the result source, aligns and sign/zero-extends load data, and drives a single-cycle registered write (wen/addr/data) into the register file. Also exports the same registered write as a forwarding source, flags faulting loads, and keeps a 64-bit retired-instruction counter.

## Interface
- `XLEN`: 32, from the shared config include; datapath width.
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_rstn`  in  1  reset; asynchronous, active-low.
- `i_mem_valid`  in  1  memory stage presents an instruction.
- `o_mem_ready`  out  1  stage accepts this cycle; equals `~i_wb_stall`.
- `i_wb_stall`  in  1  backpressure from hazard unit.
- `i_flush`  in  1  kill the instruction being accepted this cycle.
- `i_mem_rd_wen`  in  1  instruction writes rd.
- `i_mem_rd_addr`  in  5  destination register.
- `i_mem_wb_sel`  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 treated as ALU.
- `i_mem_funct3`  in  3  load width/sign encoding.
- `i_mem_alu_result`  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- `i_mem_pc_plus4`  in  XLEN  link value for JAL/JALR.
- `i_mem_load_data`  in  XLEN  raw aligned 32-bit word from data memory.
- `o_regfile_rd_wen`  out  1  register-file write enable.
- `o_regfile_rd_addr`  out  5  register-file write address.
- `o_regfile_rd_data`  out  XLEN  register-file write data.
- `o_fwd_valid`  out  1  forwarding source valid; equals `o_regfile_rd_wen`.
- `o_load_fault`  out  1  one-cycle pulse: misaligned or illegal-funct3 load.
- `o_instret`  out  64  retired-instruction count.

## Operation
- Accept = `i_mem_valid && o_mem_ready`. On an accepting edge, the output register captures the instruction. On any other edge, it loads a bubble: wen 0, addr 0, data 0, fault 0.
- Each accepted instruction therefore drives the write port for exactly one cycle. A stall never repeats a write.
- Flush: accept with `i_flush`=1 captures a bubble. No write, no fault, no instret increment. Flush does not affect the instruction already held in the output register.
- Load alignment (`wb_sel`=1), offset = `alu_result[1:0]`:
  - LB (000) / LBU (100): byte at offset*8, sign-/zero-extended.
  - LH (001) / LHU (101): halfword at offset 0 or 2. Offset 1 or 3 is a fault.
  - LW (010): offset must be 0, else fault.
  - funct3 011/110/111: fault.
- Fault: `o_load_fault`=1 and `o_regfile_rd_wen`=0 for that instruction. The instruction still counts as retired.
- `o_regfile_rd_wen` = accepted & not flushed & `i_mem_rd_wen` & (rd != 0) & no fault.
- `o_instret` increments by 1 on each accepted, non-flushed instruction, whether or not it writes. It wraps from 2^64-1 to 0.

## Timing
- Reset (async assert, sync release): all outputs 0, `o_instret` 0. `o_mem_ready` follows `~i_wb_stall` even during reset, but nothing is captured while `i_rstn`=0.
- Latency: accepted at edge N → write port valid in cycle N..N+1 → register file updated at edge N+1.
- The register file reads combinationally. The decode stage must forward from `o_fwd_*` when rd matches, because the write lands only at the next edge.
- `o_instret` is updated at the accepting edge and reflects the new count in the same cycle the write port is driven.
- Simultaneous `i_flush` and `i_wb_stall`: nothing is accepted; the flush has no effect (the memory stage holds its instruction).
- Reset asserted mid-operation: the pending write is dropped immediately (wen goes to 0 asynchronously) and the counter is cleared.

## Structure
- `wb_sel` codes and load funct3 codes are defined as named constants in the shared config include alongside `XLEN`.
- One combinational sub-module, `riscv_load_align`, with inputs (funct3, offset, word) and outputs (data, fault). It is reused by the future misaligned-access trap logic.
- The output register and instret counter live in the top module.

## Test plan
- LW, `alu_result`=0x100, word 0xDEADBEEF, rd=5 → one cycle later wen=1, addr=5, data 0xDEADBEEF; instret 0→1.
- LB offset 3, word 0x80FF_0000; LBU offset 2, same word → data 0xFFFFFF80 and 0x000000FF respectively.
- LH offset 1 → `o_load_fault` pulse, wen=0, instret increments. Repeat with funct3 011 → same response.
- JAL (`wb_sel`=2, pc_plus4 0x0000_0104, rd=1) followed by an ALU op to rd=0 → first writes 0x104 to x1; second has wen=0 and is still counted.
- `i_wb_stall` held for 3 cycles with valid high → `o_mem_ready`=0, wen=0 for all 3 cycles, no instret change; the instruction is accepted on the first unstalled edge.
- Accept with `i_flush`=1 → no write, no count. Assert `i_rstn`=0 while wen=1 → outputs 0 immediately and instret reads 0.

Source files
------------

// File: rtl/riscv_writeback_stage_pkg.sv
// Shared configuration for the writeback stage: datapath width, result-source
// codes and load funct3 encodings.
package riscv_writeback_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_ALT  = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/riscv_writeback_stage_if.sv
// Memory-stage to writeback-stage instruction handoff with valid/ready.
interface riscv_writeback_stage_if;
  import riscv_writeback_stage_pkg::*;

  logic            mem_valid;
  logic            mem_ready;
  logic            rd_wen;
  logic [4:0]      rd_addr;
  wb_sel_e         wb_sel;
  logic [2:0]      funct3;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] load_data;

  modport master (
    output mem_valid, rd_wen, rd_addr, wb_sel, funct3, alu_result, pc_plus4, load_data,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, rd_wen, rd_addr, wb_sel, funct3, alu_result, pc_plus4, load_data,
    output mem_ready
  );

endinterface

// File: rtl/riscv_load_align.sv
// Combinational load extraction: selects byte/halfword/word from an aligned
// memory word, extends it, and flags misaligned or illegal load encodings.
module riscv_load_align
  import riscv_writeback_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [XLEN-1:0] s;
    s = $signed(b);
    return sgn ? s : {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [XLEN-1:0] s;
    s = $signed(h);
    return sgn ? s : {{(XLEN-16){1'b0}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    data     = '0;
    fault    = 1'b0;
    unique case (funct3)
      F3_LB:   data = ext8(byte_sel, 1'b1);
      F3_LBU:  data = ext8(byte_sel, 1'b0);
      F3_LH: begin
        data  = ext16(half_sel, 1'b1);
        fault = offset[0];
      end
      F3_LHU: begin
        data  = ext16(half_sel, 1'b0);
        fault = offset[0];
      end
      F3_LW: begin
        data  = word;
        fault = (offset != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_writeback_stage.sv
// RV32I writeback stage: result select, registered single-cycle register-file
// write (also the forwarding source), load-fault pulse and retire counter.
module riscv_writeback_stage
  import riscv_writeback_stage_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rstn,
  riscv_writeback_stage_if.slave mem,
  input  logic                  i_wb_stall,
  input  logic                  i_flush,
  output logic                  o_regfile_rd_wen,
  output logic [4:0]            o_regfile_rd_addr,
  output logic [XLEN-1:0]       o_regfile_rd_data,
  output logic                  o_fwd_valid,
  output logic                  o_load_fault,
  output logic [63:0]           o_instret
);

  logic            accept;
  logic            retire;
  logic [XLEN-1:0] load_val;
  logic            align_fault;
  logic            fault;
  logic [XLEN-1:0] result;

  logic            vld_p0;
  logic [4:0]      addr_p0;
  logic [XLEN-1:0] data_p0;
  logic            fault_p0;
  logic [63:0]     instret_p0;

  riscv_load_align u_load_align (
    .funct3 (mem.funct3),
    .offset (mem.alu_result[1:0]),
    .word   (mem.load_data),
    .data   (load_val),
    .fault  (align_fault)
  );

  assign mem.mem_ready = ~i_wb_stall;
  assign accept        = mem.mem_valid & ~i_wb_stall;
  assign retire        = accept & ~i_flush;
  assign fault         = (mem.wb_sel == WB_LOAD) & align_fault;

  always_comb begin
    result = mem.alu_result;
    unique case (mem.wb_sel)
      WB_LOAD: result = load_val;
      WB_PC4:  result = mem.pc_plus4;
      default: result = mem.alu_result;
    endcase
  end

  // Stage p0: output register; every non-retiring edge loads a bubble so a
  // write is presented for exactly one cycle and never repeated on stall.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p0     <= 1'b0;
      addr_p0    <= '0;
      data_p0    <= '0;
      fault_p0   <= 1'b0;
      instret_p0 <= '0;
    end else if (retire) begin
      vld_p0     <= mem.rd_wen & (mem.rd_addr != 5'd0) & ~fault;
      addr_p0    <= mem.rd_addr;
      data_p0    <= result;
      fault_p0   <= fault;
      instret_p0 <= instret_p0 + 64'd1;
    end else begin
      vld_p0     <= 1'b0;
      addr_p0    <= '0;
      data_p0    <= '0;
      fault_p0   <= 1'b0;
    end
  end

  assign o_regfile_rd_wen  = vld_p0;
  assign o_regfile_rd_addr = addr_p0;
  assign o_regfile_rd_data = data_p0;
  assign o_fwd_valid       = vld_p0;
  assign o_load_fault      = fault_p0;
  assign o_instret         = instret_p0;

endmodule
